// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. One clock (uart_clk), asynchronous active-high reset.
// The line passes through a two-flop synchronizer. A falling edge seen in IDLE
// starts a frame. The start, data and stop bits are each sampled once, near the
// middle of the bit, using a down-counter that is reloaded with DIV-1 per bit.
// Optional feature: define UART_RX_DISPLAY_EN to print each received byte and
// each framing error on the simulation console.
module uart_rx #(
    parameter     NAME = "UART",
    parameter int DIV  = 50
) (
    input  logic       uart_clk,
    input  logic       uart_rst,
    input  logic       rx_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    // Refuse to elaborate with a bit period the counter cannot express
    if (DIV < 4 || DIV > 65535) begin : g_div_check
        $error("%s: DIV must be in 4..65535", NAME);
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // Counter reload values: half a bit to reach mid-start, one full bit between samples
    localparam logic [15:0] HALF_LOAD = 16'(DIV / 2 - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(DIV - 1);

    state_t      state;
    state_t      state_next;
    logic        sync1;
    logic        sync2;
    logic        sync_prev;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_next;
    logic [7:0]  shift;
    logic [7:0]  shift_next;
    logic [7:0]  byte_next;
    logic        valid_next;
    logic        err_next;
    logic        cnt_zero;

    assign cnt_zero = (cnt == 16'd0);
    assign rx_busy  = (state != IDLE);

    // Bring the asynchronous line into the clock domain; sync_prev is the prior synchronized value for edge detection
    always_ff @(posedge uart_clk or posedge uart_rst) begin
        if (uart_rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx_data;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // State, counters, shift register and registered output pulses
    always_ff @(posedge uart_clk or posedge uart_rst) begin
        if (uart_rst) begin
            state        <= IDLE;
            cnt          <= 16'd0;
            bit_idx      <= 3'd0;
            shift        <= 8'h00;
            rx_byte      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            bit_idx      <= bit_idx_next;
            shift        <= shift_next;
            rx_byte      <= byte_next;
            rx_valid     <= valid_next;
            rx_frame_err <= err_next;
        end
    end

    // Next-state logic; outside IDLE and WAIT_IDLE the line is looked at only when the counter hits zero
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        byte_next    = rx_byte;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        case (state)
            IDLE: begin
                if (!sync2 && sync_prev) begin
                    state_next = START;
                    cnt_next   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (!sync2) begin
                        state_next   = DATA;
                        cnt_next     = BIT_LOAD;
                        bit_idx_next = 3'd0;
                    end else begin
                        // The line went high again before mid-start, so treat the edge as a glitch
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_next = {sync2, shift[7:1]};
                    cnt_next   = BIT_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    if (sync2) begin
                        byte_next  = shift;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            WAIT_IDLE: begin
                // A held-low break stays here, so it reports only one framing error
                if (sync2) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef UART_RX_DISPLAY_EN
    // Console trace of received characters and framing errors
    always @(posedge uart_clk) begin
        if (rx_valid) begin
            $display("[%s]: %c", NAME, rx_byte);
        end
        if (rx_frame_err) begin
            $display("[%s]: framing error", NAME);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: the bench drives serial frames and queues the outcome it
// expects for each one. A monitor compares every pulse from the receiver against
// the front of that queue.
module tb_uart_rx;

    localparam int DIV     = 50;
    localparam int ERR_TAG = 256;
    // Cycles from driving the start bit low to rx_valid being visible: 2 synchronizer flops,
    // 1 cycle for edge detection, then DIV/2 + 9*DIV to the stop-bit sample.
    localparam int LAT     = 3 + DIV / 2 + 9 * DIV;

    logic       uart_clk = 1'b0;
    logic       uart_rst = 1'b1;
    logic       rx_data  = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_q[$];
    int   valid_count = 0;
    int   ferr_count  = 0;
    int   last_valid_cyc = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(.NAME("UART0"), .DIV(DIV)) dut (
        .uart_clk     (uart_clk),
        .uart_rst     (uart_rst),
        .rx_data      (rx_data),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 uart_clk = ~uart_clk;

    always @(posedge uart_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare each output pulse against the scoreboard
    always @(negedge uart_clk) begin
        if (!uart_rst) begin
            if (rx_valid && rx_frame_err) check("valid_and_err", 1, 0);
            if (rx_valid) begin
                valid_count++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
                else check("rx_byte", {24'd0, rx_byte}, exp_q.pop_front());
                last_good = rx_byte;
            end else if (rx_frame_err) begin
                ferr_count++;
                if (exp_q.size() == 0) check("unexpected_err", 1, 0);
                else check("frame_err", ERR_TAG, exp_q.pop_front());
                check("byte_kept", {24'd0, rx_byte}, {24'd0, last_good});
            end
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx_data = b;
        wait_cycles(DIV);
    endtask

    // Drive one frame starting just after a rising edge; queue the expected result first
    task automatic send_frame(input logic [7:0] b, input logic stop, output int start_cyc);
        if (stop) exp_q.push_back(int'(b));
        else exp_q.push_back(ERR_TAG);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    initial begin
        int s0;
        int s1;
        int v1;
        int n;
        int vc;
        logic [7:0] ff;

        // Reset state
        wait_cycles(3);
        check("rst_byte", {24'd0, rx_byte}, 0);
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_err", {31'd0, rx_frame_err}, 0);
        check("rst_busy", {31'd0, rx_busy}, 0);
        uart_rst = 1'b0;
        wait_cycles(10);

        // Single byte with latency check
        send_frame(8'h41, 1'b1, s0);
        check("lat_0x41", last_valid_cyc - s0, LAT);
        wait_cycles(20);

        // Back-to-back frames with no idle gap
        send_frame(8'h55, 1'b1, s0);
        v1 = last_valid_cyc;
        send_frame(8'hAA, 1'b1, s1);
        check("b2b_spacing", last_valid_cyc - v1, 10 * DIV);
        wait_cycles(20);

        // Short glitch: busy must return low and no pulse may appear
        rx_data = 1'b0;
        wait_cycles(10);
        rx_data = 1'b1;
        n = 0;
        while (rx_busy && n < 30) begin
            wait_cycles(1);
            n++;
        end
        check("glitch_busy", {31'd0, rx_busy}, 0);
        wait_cycles(DIV);

        // Bad stop bit followed by a long break, then a good frame
        send_frame(8'h3C, 1'b0, s0);
        rx_data = 1'b0;
        wait_cycles(2000);
        rx_data = 1'b1;
        wait_cycles(20);
        check("err_count", ferr_count, 1);
        send_frame(8'h31, 1'b1, s0);
        wait_cycles(20);

        // Reset in the middle of data bit 4 of 0xFF discards the frame
        ff = 8'hFF;
        vc = valid_count;
        rx_data = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 4; i++) send_bit(ff[i]);
        rx_data = ff[4];
        wait_cycles(DIV / 2);
        uart_rst = 1'b1;
        #1;
        check("midrst_byte", {24'd0, rx_byte}, 0);
        check("midrst_valid", {31'd0, rx_valid}, 0);
        check("midrst_err", {31'd0, rx_frame_err}, 0);
        check("midrst_busy", {31'd0, rx_busy}, 0);
        wait_cycles(3);
        uart_rst = 1'b0;
        last_good = 8'h00;
        wait_cycles(10 * DIV);
        check("midrst_no_pulse", valid_count - vc, 0);
        send_frame(8'h7E, 1'b1, s0);
        wait_cycles(20);

        // Final bookkeeping
        check("valid_total", valid_count, 5);
        check("err_total", ferr_count, 1);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter NAME, default "UART"; instance label used in console output.
REQ-002 SHALL have parameter DIV, default 50; uart_clk cycles per serial bit, legal range 4..65535.
REQ-003 SHALL have port uart_clk, input, 1 bit; the single clock; all logic on its rising edge.
REQ-004 SHALL have port uart_rst, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 1 bit; serial line, idle high, asynchronous to uart_clk.
REQ-006 SHALL have port rx_byte, output, 8 bits; last correctly received byte.
REQ-007 SHALL have port rx_valid, output, 1 bit; one-cycle pulse when rx_byte is updated.
REQ-008 SHALL have port rx_frame_err, output, 1 bit; one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port rx_busy, output, 1 bit; high whenever the state is not IDLE.

Function
REQ-010 SHALL receive 8N1 frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), no parity.
REQ-011 SHALL pass rx_data through a 2-flop synchronizer; only the synchronized value is used.
REQ-012 SHALL implement states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 IDLE: synchronized value 0 while previous synchronized value 1 -> START; bit counter loaded with DIV/2-1 (integer division).
REQ-014 START: when the counter reaches 0, sample the line: low -> DATA with counter DIV-1 and bit index 0; high -> IDLE as a glitch, with no output pulse.
REQ-015 DATA: each time the counter reaches 0, shift the sampled bit into the shift-register MSB and reload DIV-1; after bit index 7 go to STOP.
REQ-016 STOP: when the counter reaches 0, sample the line: high -> rx_byte <= shift register, rx_valid=1 for that one cycle, next state IDLE.
REQ-017 STOP sample low -> rx_frame_err=1 for one cycle, rx_byte unchanged, next state WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until the synchronized line is high, then IDLE; a held-low break yields exactly one rx_frame_err.
REQ-019 Latency: the stop bit is sampled (DIV/2)+9*DIV cycles after the cycle in which the falling edge is detected; rx_valid asserts on that edge.
REQ-020 Back-to-back frames: a start edge arriving one cycle after STOP returns to IDLE SHALL be accepted, with no gap bits required.
REQ-021 rx_valid and rx_frame_err SHALL never be high in the same cycle.
REQ-022 Line activity outside IDLE SHALL only be observed at the sample points defined above.

Reset
REQ-023 uart_rst high SHALL force immediately: state IDLE, synchronizer flops 1, counter 0, bit index 0, shift register 0x00.
REQ-024 uart_rst high SHALL also force rx_byte 0x00, rx_valid 0, rx_frame_err 0, rx_busy 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; no pulse on release.
REQ-026 After release, a frame SHALL only be accepted after a new high-to-low transition.

Configuration
REQ-027 With macro UART_RX_DISPLAY_EN defined, each rx_valid SHALL print one simulation line "[<NAME>]: <char>" with the byte as an ASCII character.
REQ-028 Under UART_RX_DISPLAY_EN, each rx_frame_err SHALL print "[<NAME>]: framing error".
REQ-029 Without UART_RX_DISPLAY_EN, no display code SHALL be compiled; port behaviour is identical in both builds.

Verification
REQ-030 DIV=50, send 0x41 -> one rx_valid pulse, rx_byte=0x41 exactly 475 cycles after edge detection; with the macro, prints "[UART0]: A".
REQ-031 Back-to-back 0x55 then 0xAA with no idle gap -> two rx_valid pulses 500 cycles apart, bytes 0x55 and 0xAA, rx_frame_err never set.
REQ-032 10-cycle low glitch on an idle line -> no rx_valid, no rx_frame_err, rx_busy returns low within 27 cycles.
REQ-033 Frame 0x3C with stop bit low, line held low 2000 cycles then high -> exactly one rx_frame_err, rx_byte unchanged, then 0x31 is received correctly.
REQ-034 uart_rst pulsed during data bit 4 of 0xFF -> all outputs 0 immediately, no pulse afterwards; the next frame 0x7E is received correctly.
